data_path: RTL and testbench
============================

Name: data_path

Overview:
8-bit datapath of the APS4 processor, directly downstream of control_unit.
- Holds PC, IR, MAR, A, B and CCR, plus the two internal buses and the ALU.
- Executes register transfers commanded each cycle by control_unit's load and select strobes.
- Returns IR and CCR_Result to control_unit, drives address and write data to the memory block, and takes read data from it.

Parameters:
DATA_WIDTH, 8, width of data, address and every register except CCR; the design is verified only at 8.

Ports:
Clk  input  1  system clock, all registers update on its rising edge
Reset  input  1  asynchronous, active-low; clears all registers immediately
IR_Load  input  1  IR <= Bus2
MAR_Load  input  1  MAR <= Bus2
PC_Load  input  1  PC <= Bus2
PC_Inc  input  1  PC <= PC + 1
A_Load  input  1  A <= Bus2
B_Load  input  1  B <= Bus2
CCR_Load  input  1  CCR <= ALU flags
ALU_Sel  input  3  ALU operation select
Bus1_Sel  input  2  Bus1 source select
Bus2_Sel  input  2  Bus2 source select
from_memory  input  8  memory read data
address  output  8  memory address, equals MAR
to_memory  output  8  memory write data, equals Bus1
IR  output  8  instruction register, to control_unit
CCR_Result  output  4  condition codes {N,Z,V,C}, to control_unit

Behaviour:
- Reset asserted (low): PC, IR, MAR, A, B and CCR go to 0 asynchronously, so address, IR and CCR_Result read 0x00/0x0.
  - Reset in any cycle, including mid-instruction, discards that cycle's loads.
  - Loads resume on the first rising edge after Reset returns high.
- Bus1 mux (combinational):
  - 00 = PC, 01 = A, 10 = B, 11 = 0x00.
- Bus2 mux (combinational):
  - 00 = ALU result, 01 = Bus1, 10 = from_memory, 11 = 0x00.
- ALU (combinational). X = Bus1, Y = B, 8-bit result.
  - 000 ADD X+Y
  - 001 SUB X-Y
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 INC X+1
  - 110 DEC X-1
  - 111 pass X
- ALU flags:
  - N = result[7].
  - Z = (result == 0).
  - V = two's-complement overflow for ADD/SUB/INC/DEC, 0 otherwise.
  - C = carry-out for ADD/INC, borrow (X < subtrahend, unsigned) for SUB/DEC, 0 for logic ops and pass.
- All register writes are single-cycle: values are sampled on the rising edge with the strobes and selects present, and are visible on outputs the same edge (zero extra latency).
- PC update:
  - PC_Load has priority over PC_Inc when both are high.
  - PC_Inc wraps 0xFF -> 0x00 with no flag.
- Simultaneous loads are legal; all loaded registers capture the same Bus2 value, e.g. A_Load with B_Load, or IR_Load with MAR_Load.
- CCR_Load captures the flags of the current ALU result, independent of Bus2_Sel and of which register is loaded.
- No strobe asserted: every register holds its value.
- address = MAR and to_memory = Bus1 combinationally; the memory's write strobe comes from control_unit, not from this block.
- Unused select codes (11) yield 0x00 and must not cause X propagation.

Decomposition:
- Shared package cpu_pkg:
  - Bus1 select encodings: PC, A, B.
  - Bus2 select encodings: ALU, BUS1, MEM.
  - ALU_Sel opcodes.
  - CCR bit indices: N=3, Z=2, V=1, C=0.
  - DATA_WIDTH default.
- Sub-module alu: combinational, inputs X, Y, ALU_Sel; outputs result[7:0] and NZVC[3:0]. It is instantiated once in data_path.
- Registers and muxes stay inline in data_path.

Test Plan:
- Reset low mid-run with A=0x55, PC=0x12 -> all registers 0x00 before the next clock edge; address=0x00, CCR_Result=0x0.
- Fetch sequence:
  - Bus1_Sel=00, Bus2_Sel=01, MAR_Load with PC=0x00 -> address=0x00.
  - Next cycle Bus2_Sel=10, IR_Load+PC_Inc with from_memory=0x86 -> IR=0x86, PC=0x01.
- A=0x7F, B=0x01, ALU_Sel=000, Bus1_Sel=01, Bus2_Sel=00, A_Load+CCR_Load -> A=0x80, CCR_Result=1010 (N=1, Z=0, V=1, C=0).
- A=0x05, B=0x05, SUB with CCR_Load -> result 0x00, CCR_Result=0100.
- A=0x03, B=0x05, SUB -> result 0xFE, CCR_Result=1001 (borrow).
- PC wrap and priority:
  - PC=0xFF, PC_Inc -> PC=0x00.
  - PC_Load+PC_Inc with Bus2_Sel=10, from_memory=0x40 -> PC=0x40.
- Store path: Bus1_Sel=01 with A=0x3C -> to_memory=0x3C; Bus1_Sel=11 -> to_memory=0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the APS4 datapath: bus selects, ALU opcodes and CCR bit positions.
package cpu_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        BUS1_PC   = 2'b00,
        BUS1_A    = 2'b01,
        BUS1_B    = 2'b10,
        BUS1_ZERO = 2'b11
    } bus1_sel_e;

    typedef enum logic [1:0] {
        BUS2_ALU  = 2'b00,
        BUS2_BUS1 = 2'b01,
        BUS2_MEM  = 2'b10,
        BUS2_ZERO = 2'b11
    } bus2_sel_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_INC  = 3'b101,
        ALU_DEC  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

endpackage

// File: rtl/data_path_if.sv
// Control strobes from control_unit plus the memory-side bus of the datapath.
interface data_path_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  IR_Load;
    logic                  MAR_Load;
    logic                  PC_Load;
    logic                  PC_Inc;
    logic                  A_Load;
    logic                  B_Load;
    logic                  CCR_Load;
    logic [2:0]            ALU_Sel;
    logic [1:0]            Bus1_Sel;
    logic [1:0]            Bus2_Sel;
    logic [DATA_WIDTH-1:0] from_memory;
    logic [DATA_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] to_memory;
    logic [DATA_WIDTH-1:0] IR;
    logic [3:0]            CCR_Result;

    modport master (
        output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
        output ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
        input  address, to_memory, IR, CCR_Result
    );

    modport slave (
        input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
        input  ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
        output address, to_memory, IR, CCR_Result
    );
endinterface

// File: rtl/data_path_alu.sv
// Combinational ALU: X comes from Bus1, Y from register B; flags are {N,Z,V,C}.
module alu
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] X,
    input  logic [DATA_WIDTH-1:0] Y,
    input  logic [2:0]            ALU_Sel,
    output logic [DATA_WIDTH-1:0] result,
    output logic [3:0]            NZVC
);
    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    logic [DATA_WIDTH:0]   wide;
    logic [DATA_WIDTH-1:0] operand;
    logic                  carry;
    logic                  ovf;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise unlisted paths infer latches.
        wide    = '0;
        operand = Y;
        carry   = 1'b0;
        ovf     = 1'b0;
        result  = '0;
        unique case (alu_op_e'(ALU_Sel))
            ALU_ADD, ALU_INC: begin
                operand = (alu_op_e'(ALU_Sel) == ALU_INC) ? ONE : Y;
                wide    = {1'b0, X} + {1'b0, operand};
                result  = wide[MSB:0];
                carry   = wide[DATA_WIDTH];
                ovf     = (X[MSB] == operand[MSB]) && (result[MSB] != X[MSB]);
            end
            ALU_SUB, ALU_DEC: begin
                // The extra top bit of the widened difference is the unsigned borrow.
                operand = (alu_op_e'(ALU_Sel) == ALU_DEC) ? ONE : Y;
                wide    = {1'b0, X} - {1'b0, operand};
                result  = wide[MSB:0];
                carry   = wide[DATA_WIDTH];
                ovf     = (X[MSB] != operand[MSB]) && (result[MSB] != X[MSB]);
            end
            ALU_AND:  result = X & Y;
            ALU_OR:   result = X | Y;
            ALU_XOR:  result = X ^ Y;
            ALU_PASS: result = X;
            default:  result = '0;
        endcase
        NZVC        = '0;
        NZVC[CCR_N] = result[MSB];
        NZVC[CCR_Z] = (result == '0);
        NZVC[CCR_V] = ovf;
        NZVC[CCR_C] = carry;
    end
endmodule

// File: rtl/data_path.sv
// APS4 datapath: PC/IR/MAR/A/B/CCR registers, the two internal buses and the ALU.
module data_path
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    data_path_if.slave  bus
);
    logic [DATA_WIDTH-1:0] pc, ir, mar, a, b;
    logic [3:0]            ccr;
    logic [DATA_WIDTH-1:0] bus1, bus2, alu_result;
    logic [3:0]            alu_flags;

    // Unused select codes fall to zero so no X ever reaches a register.
    always_comb begin
        bus1 = '0;
        case (bus1_sel_e'(bus.Bus1_Sel))
            BUS1_PC: bus1 = pc;
            BUS1_A:  bus1 = a;
            BUS1_B:  bus1 = b;
            default: bus1 = '0;
        endcase
    end

    always_comb begin
        bus2 = '0;
        case (bus2_sel_e'(bus.Bus2_Sel))
            BUS2_ALU:  bus2 = alu_result;
            BUS2_BUS1: bus2 = bus1;
            BUS2_MEM:  bus2 = bus.from_memory;
            default:   bus2 = '0;
        endcase
    end

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .X       (bus1),
        .Y       (b),
        .ALU_Sel (bus.ALU_Sel),
        .result  (alu_result),
        .NZVC    (alu_flags)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            a   <= '0;
            b   <= '0;
            ccr <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge buses, even on simultaneous loads.
            if (bus.IR_Load)  ir  <= bus2;
            if (bus.MAR_Load) mar <= bus2;
            if (bus.A_Load)   a   <= bus2;
            if (bus.B_Load)   b   <= bus2;
            if (bus.CCR_Load) ccr <= alu_flags;
            if (bus.PC_Load)     pc <= bus2;
            else if (bus.PC_Inc) pc <= pc + DATA_WIDTH'(1);
        end
    end

    assign bus.address    = mar;
    assign bus.to_memory  = bus1;
    assign bus.IR         = ir;
    assign bus.CCR_Result = ccr;
endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path; register contents are observed through to_memory via Bus1.
module tb_data_path;
    import cpu_pkg::*;

    logic Clk;
    logic Reset;
    int   n_cmp = 0;
    int   n_err = 0;

    data_path_if #(.DATA_WIDTH(8)) bus ();

    data_path #(.DATA_WIDTH(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_strobes();
        bus.IR_Load  = 1'b0;
        bus.MAR_Load = 1'b0;
        bus.PC_Load  = 1'b0;
        bus.PC_Inc   = 1'b0;
        bus.A_Load   = 1'b0;
        bus.B_Load   = 1'b0;
        bus.CCR_Load = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        clear_strobes();
    endtask

    task automatic mem_load(input logic [7:0] v, input logic la, input logic lb,
                            input logic lpc, input logic lir, input logic lmar);
        bus.Bus2_Sel    = BUS2_MEM;
        bus.from_memory = v;
        bus.A_Load      = la;
        bus.B_Load      = lb;
        bus.PC_Load     = lpc;
        bus.IR_Load     = lir;
        bus.MAR_Load    = lmar;
        tick();
    endtask

    task automatic alu_step(input alu_op_e op, input bus1_sel_e src);
        bus.ALU_Sel  = op;
        bus.Bus1_Sel = src;
        bus.Bus2_Sel = BUS2_ALU;
        bus.A_Load   = 1'b1;
        bus.CCR_Load = 1'b1;
        tick();
    endtask

    task automatic peek(input bus1_sel_e src);
        bus.Bus1_Sel = src;
        #1;
    endtask

    initial begin
        clear_strobes();
        bus.ALU_Sel     = ALU_ADD;
        bus.Bus1_Sel    = BUS1_PC;
        bus.Bus2_Sel    = BUS2_ALU;
        bus.from_memory = 8'h00;
        Reset           = 1'b0;
        #2;
        check("por_address", bus.address, 8'h00);
        check("por_ir", bus.IR, 8'h00);
        check("por_ccr", {4'h0, bus.CCR_Result}, 8'h00);
        check("por_pc", bus.to_memory, 8'h00);
        @(negedge Clk);
        Reset = 1'b1;

        // Populate every register, then pull reset low between edges.
        mem_load(8'h55, 1, 0, 0, 1, 1);
        check("simul_ir_mar_address", bus.address, 8'h55);
        check("simul_ir_mar_ir", bus.IR, 8'h55);
        mem_load(8'h12, 0, 0, 1, 0, 0);
        bus.Bus1_Sel = BUS1_ZERO;
        bus.ALU_Sel  = ALU_PASS;
        bus.CCR_Load = 1'b1;
        tick();
        check("pass_zero_ccr", {4'h0, bus.CCR_Result}, 8'h04);
        peek(BUS1_A);
        check("pre_reset_a", bus.to_memory, 8'h55);
        peek(BUS1_PC);
        check("pre_reset_pc", bus.to_memory, 8'h12);

        Reset = 1'b0;
        #1;
        check("async_reset_pc", bus.to_memory, 8'h00);
        check("async_reset_address", bus.address, 8'h00);
        check("async_reset_ir", bus.IR, 8'h00);
        check("async_reset_ccr", {4'h0, bus.CCR_Result}, 8'h00);
        peek(BUS1_A);
        check("async_reset_a", bus.to_memory, 8'h00);
        mem_load(8'hAA, 1, 0, 0, 0, 0);
        peek(BUS1_A);
        check("load_blocked_in_reset", bus.to_memory, 8'h00);
        Reset = 1'b1;
        mem_load(8'h66, 1, 0, 0, 0, 0);
        peek(BUS1_A);
        check("load_after_reset", bus.to_memory, 8'h66);

        // Fetch: MAR <= PC, then IR <= memory with PC increment.
        mem_load(8'h77, 0, 0, 0, 0, 1);
        check("mar_preload", bus.address, 8'h77);
        bus.Bus1_Sel = BUS1_PC;
        bus.Bus2_Sel = BUS2_BUS1;
        bus.MAR_Load = 1'b1;
        tick();
        check("fetch_mar", bus.address, 8'h00);
        bus.Bus2_Sel    = BUS2_MEM;
        bus.from_memory = 8'h86;
        bus.IR_Load     = 1'b1;
        bus.PC_Inc      = 1'b1;
        tick();
        check("fetch_ir", bus.IR, 8'h86);
        peek(BUS1_PC);
        check("fetch_pc_inc", bus.to_memory, 8'h01);

        // ALU operations, result written back to A with flags.
        mem_load(8'h7F, 1, 0, 0, 0, 0);
        mem_load(8'h01, 0, 1, 0, 0, 0);
        alu_step(ALU_ADD, BUS1_A);
        peek(BUS1_A);
        check("add_ovf_result", bus.to_memory, 8'h80);
        check("add_ovf_ccr", {4'h0, bus.CCR_Result}, 8'h0A);

        mem_load(8'h05, 1, 1, 0, 0, 0);
        peek(BUS1_B);
        check("simul_ab_b", bus.to_memory, 8'h05);
        alu_step(ALU_SUB, BUS1_A);
        peek(BUS1_A);
        check("sub_zero_result", bus.to_memory, 8'h00);
        check("sub_zero_ccr", {4'h0, bus.CCR_Result}, 8'h04);

        mem_load(8'h03, 1, 0, 0, 0, 0);
        alu_step(ALU_SUB, BUS1_A);
        peek(BUS1_A);
        check("sub_borrow_result", bus.to_memory, 8'hFE);
        check("sub_borrow_ccr", {4'h0, bus.CCR_Result}, 8'h09);

        mem_load(8'hFF, 1, 0, 0, 0, 0);
        alu_step(ALU_INC, BUS1_A);
        peek(BUS1_A);
        check("inc_wrap_result", bus.to_memory, 8'h00);
        check("inc_wrap_ccr", {4'h0, bus.CCR_Result}, 8'h05);

        mem_load(8'h80, 1, 0, 0, 0, 0);
        alu_step(ALU_DEC, BUS1_A);
        peek(BUS1_A);
        check("dec_ovf_result", bus.to_memory, 8'h7F);
        check("dec_ovf_ccr", {4'h0, bus.CCR_Result}, 8'h02);

        alu_step(ALU_AND, BUS1_A);
        peek(BUS1_A);
        check("and_result", bus.to_memory, 8'h05);
        check("and_ccr", {4'h0, bus.CCR_Result}, 8'h00);

        alu_step(ALU_XOR, BUS1_A);
        peek(BUS1_A);
        check("xor_result", bus.to_memory, 8'h00);
        check("xor_ccr", {4'h0, bus.CCR_Result}, 8'h04);

        mem_load(8'hF0, 1, 0, 0, 0, 0);
        alu_step(ALU_OR, BUS1_A);
        peek(BUS1_A);
        check("or_result", bus.to_memory, 8'hF5);
        check("or_ccr", {4'h0, bus.CCR_Result}, 8'h08);

        // CCR follows the ALU even while Bus2 carries memory and nothing else loads.
        bus.ALU_Sel     = ALU_ADD;
        bus.Bus1_Sel    = BUS1_B;
        bus.Bus2_Sel    = BUS2_MEM;
        bus.from_memory = 8'h99;
        bus.CCR_Load    = 1'b1;
        tick();
        check("ccr_only_ccr", {4'h0, bus.CCR_Result}, 8'h00);
        peek(BUS1_A);
        check("ccr_only_a_held", bus.to_memory, 8'hF5);

        tick();
        check("hold_ir", bus.IR, 8'h86);
        check("hold_address", bus.address, 8'h00);
        check("hold_a", bus.to_memory, 8'hF5);

        // PC wrap and load-over-increment priority.
        mem_load(8'hFF, 0, 0, 1, 0, 0);
        bus.PC_Inc = 1'b1;
        tick();
        peek(BUS1_PC);
        check("pc_wrap", bus.to_memory, 8'h00);
        bus.Bus2_Sel    = BUS2_MEM;
        bus.from_memory = 8'h40;
        bus.PC_Load     = 1'b1;
        bus.PC_Inc      = 1'b1;
        tick();
        peek(BUS1_PC);
        check("pc_load_priority", bus.to_memory, 8'h40);

        // Store path and unused select codes.
        mem_load(8'h3C, 1, 0, 0, 0, 0);
        peek(BUS1_A);
        check("store_a", bus.to_memory, 8'h3C);
        peek(BUS1_ZERO);
        check("store_zero_sel", bus.to_memory, 8'h00);
        bus.Bus2_Sel = BUS2_ZERO;
        bus.A_Load   = 1'b1;
        tick();
        peek(BUS1_A);
        check("bus2_zero_sel", bus.to_memory, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
